dmem_arbiter: RTL and testbench

- Shares the single-port 128x256-bit image/data memory among three requesters:
  - the camera capture path: write-only, no backpressure, highest priority;
  - the neural-net core: read-only;
  - the SPART host bridge: read/write.
- Tracks ownership of the image region with a frame-lock FSM, so the NN never reads a partially captured frame and the host never overwrites a frame awaiting inference.
- Sits between the capture FSM and the memory macro, in the pixel-clock domain.

---
 rtl/dmem_arbiter.sv | 163 ++++++++++++++++
 tb/tb_dmem_arbiter.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port image/data memory between the capture
// path (highest priority, write-only), the NN core (read-only) and the host
// bridge (read/write). A frame-lock FSM guards the image region so that the
// NN never reads a partial frame and the host never overwrites a pending one.
module dmem_arbiter #(
  parameter int ADDR_W    = 7,
  parameter int DATA_W    = 256,
  parameter int IMG_WORDS = 50
) (
  input  logic              pxlclk,
  input  logic              rst_n,
  input  logic              cap_wren,
  input  logic [ADDR_W-1:0] cap_addr,
  input  logic [DATA_W-1:0] cap_data,
  input  logic              cap_done,
  input  logic              nn_req,
  input  logic [ADDR_W-1:0] nn_addr,
  output logic              nn_gnt,
  output logic              nn_rvalid,
  input  logic              nn_img_release,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_gnt,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] rd_data,
  output logic              mem_wren,
  output logic              mem_rden,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              img_ready,
  output logic              cap_overrun
);

  localparam logic [ADDR_W-1:0] IMG_LIM = ADDR_W'(IMG_WORDS);
  localparam int STAGES = 2;

  typedef enum logic [1:0] {S_IDLE, S_CAPT, S_READY} state_e;
  typedef enum logic [1:0] {T_NONE, T_NN, T_HOST}    tag_e;

  state_e              state_q, state_d;
  logic                rr_host_q, rr_host_d;   // 1: host wins the next tie
  logic                ovr_q, ovr_d;
  logic                rdy_q;
  logic                wren_q, wren_d, rden_q, rden_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  tag_e                tag_pipe_q [STAGES];
  tag_e                tag_in;
  logic                nn_rv_q, host_rv_q;
  logic [DATA_W-1:0]   rd_data_q;

  logic cap_take, nn_elig, host_elig, nn_g, host_g;

  // Eligibility and single-cycle arbitration; capture always takes the slot
  // unless a finished frame is still locked.
  always_comb begin
    cap_take  = cap_wren && (state_q != S_READY);
    nn_elig   = nn_req && !((state_q == S_CAPT) && (nn_addr < IMG_LIM));
    host_elig = host_req && !(host_we && (host_addr < IMG_LIM) && (state_q != S_IDLE));
    nn_g      = 1'b0;
    host_g    = 1'b0;
    if (!cap_take) begin
      if (nn_elig && host_elig) begin
        nn_g   = !rr_host_q;
        host_g = rr_host_q;
      end else begin
        nn_g   = nn_elig;
        host_g = host_elig;
      end
    end
    rr_host_d = rr_host_q;
    if (nn_g)        rr_host_d = 1'b1;
    else if (host_g) rr_host_d = 1'b0;
  end

  // Next memory command and read tag; address/data hold when nothing issues.
  always_comb begin
    wren_d  = 1'b0;
    rden_d  = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    tag_in  = T_NONE;
    if (cap_take) begin
      wren_d  = 1'b1;
      addr_d  = cap_addr;
      wdata_d = cap_data;
    end else if (host_g && host_we) begin
      wren_d  = 1'b1;
      addr_d  = host_addr;
      wdata_d = host_wdata;
    end else if (host_g) begin
      rden_d  = 1'b1;
      addr_d  = host_addr;
      tag_in  = T_HOST;
    end else if (nn_g) begin
      rden_d  = 1'b1;
      addr_d  = nn_addr;
      tag_in  = T_NN;
    end
  end

  // Frame-lock FSM next state and sticky overrun flag.
  always_comb begin
    state_d = state_q;
    ovr_d   = ovr_q;
    case (state_q)
      S_IDLE:  if (cap_wren)       state_d = S_CAPT;
      S_CAPT:  if (cap_done)       state_d = S_READY;
      S_READY: if (nn_img_release) state_d = S_IDLE;
      default:                     state_d = S_IDLE;
    endcase
    if (cap_wren && (state_q == S_READY)) ovr_d = 1'b1;
  end

  // Control state, memory command register and read-return pipeline.
  always_ff @(posedge pxlclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      rr_host_q     <= 1'b0;
      ovr_q         <= 1'b0;
      rdy_q         <= 1'b0;
      wren_q        <= 1'b0;
      rden_q        <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      tag_pipe_q[0] <= T_NONE;
      tag_pipe_q[1] <= T_NONE;
      nn_rv_q       <= 1'b0;
      host_rv_q     <= 1'b0;
      rd_data_q     <= '0;
    end else begin
      state_q       <= state_d;
      rr_host_q     <= rr_host_d;
      ovr_q         <= ovr_d;
      rdy_q         <= (state_d == S_READY);
      wren_q        <= wren_d;
      rden_q        <= rden_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      tag_pipe_q[0] <= tag_in;
      tag_pipe_q[1] <= tag_pipe_q[0];
      nn_rv_q       <= (tag_pipe_q[1] == T_NN);
      host_rv_q     <= (tag_pipe_q[1] == T_HOST);
      rd_data_q     <= mem_rdata;
    end
  end

  assign nn_gnt      = nn_g;
  assign host_gnt    = host_g;
  assign nn_rvalid   = nn_rv_q;
  assign host_rvalid = host_rv_q;
  assign rd_data     = rd_data_q;
  assign mem_wren    = wren_q;
  assign mem_rden    = rden_q;
  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;
  assign img_ready   = rdy_q;
  assign cap_overrun = ovr_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios followed by random traffic,
// all checked each cycle against a rule-level model of grants, frame
// ownership, memory commands and read returns.
module tb_dmem_arbiter;
  localparam int AW = 7, DW = 256, IMG = 50;
  localparam int F_IDLE = 0, F_CAPT = 1, F_READY = 2;

  logic          pxlclk = 1'b0, rst_n = 1'b0;
  logic          cap_wren = 0, cap_done = 0, nn_req = 0, nn_img_release = 0;
  logic          host_req = 0, host_we = 0;
  logic [AW-1:0] cap_addr = '0, nn_addr = '0, host_addr = '0;
  logic [DW-1:0] cap_data = '0, host_wdata = '0;
  logic          nn_gnt, nn_rvalid, host_gnt, host_rvalid;
  logic          mem_wren, mem_rden, img_ready, cap_overrun;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, rd_data, mem_rdata;

  dmem_arbiter dut (
    .pxlclk(pxlclk), .rst_n(rst_n), .cap_wren(cap_wren), .cap_addr(cap_addr),
    .cap_data(cap_data), .cap_done(cap_done), .nn_req(nn_req), .nn_addr(nn_addr),
    .nn_gnt(nn_gnt), .nn_rvalid(nn_rvalid), .nn_img_release(nn_img_release),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_gnt(host_gnt), .host_rvalid(host_rvalid),
    .rd_data(rd_data), .mem_wren(mem_wren), .mem_rden(mem_rden),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .img_ready(img_ready), .cap_overrun(cap_overrun));

  always #5 pxlclk = ~pxlclk;

  // Memory macro: synchronous, 1-cycle read latency.
  logic [DW-1:0] macro_mem [128];
  always @(posedge pxlclk) begin
    if (mem_wren) macro_mem[mem_addr] <= mem_wdata;
    if (mem_rden) mem_rdata <= macro_mem[mem_addr];
  end

  // Reference model state.
  typedef struct { int due; bit to_nn; logic [DW-1:0] data; } rd_t;
  rd_t           pend[$];
  logic [DW-1:0] ref_mem [128];
  int            m_frame;
  bit            m_fav_nn, m_ovr, g_nn, g_host;
  bit            e_wren, e_rden;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wdata;
  int            cyc = 0, n_cmp = 0, n_bad = 0;

  function automatic logic [DW-1:0] rnd256();
    logic [DW-1:0] v;
    for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s cyc=%0d: observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_frame = F_IDLE; m_fav_nn = 1; m_ovr = 0; g_nn = 0; g_host = 0;
    e_wren = 0; e_rden = 0; e_addr = '0; e_wdata = '0;
    pend.delete();
  endtask

  // One clock: check everything visible this cycle, then advance the model.
  task automatic cycle();
    bit cap_take, nn_ok, h_ok, en, eh, xnv, xhv;
    logic [DW-1:0] xrd;
    @(negedge pxlclk);
    cap_take = cap_wren && m_frame != F_READY;
    nn_ok    = nn_req && !(m_frame == F_CAPT && nn_addr < IMG);
    h_ok     = host_req && !(host_we && host_addr < IMG && m_frame != F_IDLE);
    en = 0; eh = 0;
    if (!cap_take) begin
      if (nn_ok && h_ok) begin en = m_fav_nn; eh = !m_fav_nn; end
      else begin en = nn_ok; eh = h_ok; end
    end
    xnv = 0; xhv = 0; xrd = '0;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      xnv = pend[0].to_nn; xhv = !pend[0].to_nn; xrd = pend[0].data;
      void'(pend.pop_front());
    end
    chk("nn_gnt", nn_gnt, en);
    chk("host_gnt", host_gnt, eh);
    chk("nn_rvalid", nn_rvalid, xnv);
    chk("host_rvalid", host_rvalid, xhv);
    if (xnv || xhv) chk("rd_data", rd_data, xrd);
    chk("mem_wren", mem_wren, e_wren);
    chk("mem_rden", mem_rden, e_rden);
    chk("mem_addr", mem_addr, e_addr);
    chk("mem_wdata", mem_wdata, e_wdata);
    chk("img_ready", img_ready, m_frame == F_READY);
    chk("cap_overrun", cap_overrun, m_ovr);
    if (cap_take) begin
      e_wren = 1; e_rden = 0; e_addr = cap_addr; e_wdata = cap_data;
      ref_mem[cap_addr] = cap_data;
    end else if (eh && host_we) begin
      e_wren = 1; e_rden = 0; e_addr = host_addr; e_wdata = host_wdata;
      ref_mem[host_addr] = host_wdata;
    end else if (en || eh) begin
      e_wren = 0; e_rden = 1; e_addr = en ? nn_addr : host_addr;
      pend.push_back('{cyc + 3, en, ref_mem[e_addr]});
    end else begin
      e_wren = 0; e_rden = 0;
    end
    if (cap_wren && m_frame == F_READY) m_ovr = 1;
    case (m_frame)
      F_IDLE:  if (cap_wren) m_frame = F_CAPT;
      F_CAPT:  if (cap_done) m_frame = F_READY;
      default: if (nn_img_release) m_frame = F_IDLE;
    endcase
    if (en) m_fav_nn = 0; else if (eh) m_fav_nn = 1;
    g_nn = en; g_host = eh;
    @(posedge pxlclk); #1;
    cyc++;
  endtask

  task automatic clr_inputs();
    cap_wren = 0; cap_done = 0; nn_req = 0; nn_img_release = 0;
    host_req = 0; host_we = 0;
  endtask

  // Reset at an arbitrary point after a clock edge; all outputs must be 0.
  task automatic do_reset();
    clr_inputs();
    rst_n = 0;
    #1;
    chk("rst_nn_gnt", nn_gnt, 0);      chk("rst_host_gnt", host_gnt, 0);
    chk("rst_nn_rvalid", nn_rvalid, 0); chk("rst_host_rvalid", host_rvalid, 0);
    chk("rst_rd_data", rd_data, '0);   chk("rst_mem_wren", mem_wren, 0);
    chk("rst_mem_rden", mem_rden, 0);  chk("rst_mem_addr", mem_addr, '0);
    chk("rst_mem_wdata", mem_wdata, '0);
    chk("rst_img_ready", img_ready, 0); chk("rst_cap_overrun", cap_overrun, 0);
    repeat (2) @(posedge pxlclk);
    #1 rst_n = 1;
    model_reset();
  endtask

  initial begin
    for (int i = 0; i < 128; i++) begin
      logic [DW-1:0] v;
      v = rnd256();
      macro_mem[i] = v;
      ref_mem[i]   = v;
    end
    model_reset();
    @(posedge pxlclk); #1;
    do_reset();

    // 1: capture burst while the NN waits on image address 3
    nn_req = 1; nn_addr = 3;
    for (int a = 0; a < IMG; a++) begin
      cap_wren = 1; cap_addr = AW'(a); cap_data = rnd256();
      cycle();
    end
    cap_wren = 0; cap_done = 1;
    cycle();
    cap_done = 0;
    for (int k = 0; k < 5 && !g_nn; k++) cycle();
    nn_req = 0;
    repeat (4) cycle();

    // 2: host write into locked image, outside it, then read inside it
    host_req = 1; host_we = 1; host_addr = 10; host_wdata = rnd256();
    repeat (2) cycle();
    host_addr = 80;
    cycle();
    host_we = 0; host_addr = 10;
    cycle();
    host_req = 0;
    repeat (4) cycle();

    // 3: NN and host read contention, alternating grants
    nn_req = 1; host_req = 1; host_we = 0;
    nn_addr = AW'($urandom_range(0, 127)); host_addr = AW'($urandom_range(0, 127));
    repeat (4) begin
      cycle();
      if (g_nn) nn_addr = AW'($urandom_range(0, 127));
      if (g_host) host_addr = AW'($urandom_range(0, 127));
    end
    nn_req = 0; host_req = 0;
    repeat (4) cycle();

    // 4: capture while READY is dropped and flags overrun; release frame
    cap_wren = 1; cap_addr = 7; cap_data = rnd256();
    cycle();
    cap_wren = 0;
    repeat (2) cycle();
    nn_img_release = 1;
    cycle();
    nn_img_release = 0;
    repeat (2) cycle();

    // 5: capture and host read in the same IDLE cycle
    cap_wren = 1; cap_addr = 5; cap_data = rnd256();
    host_req = 1; host_we = 0; host_addr = 5;
    cycle();
    cap_wren = 0;
    cycle();
    host_req = 0;
    repeat (4) cycle();

    // 6: reset one cycle after an NN grant; no stale rvalid afterwards
    nn_req = 1; nn_addr = 100;
    cycle();
    nn_req = 0;
    cycle();
    do_reset();
    repeat (5) cycle();

    // Random traffic with requesters holding until granted
    for (int n = 0; n < 600; n++) begin
      if (!nn_req || g_nn) begin
        nn_req = ($urandom_range(0, 2) != 0); nn_addr = AW'($urandom_range(0, 127));
      end
      if (!host_req || g_host) begin
        host_req = ($urandom_range(0, 2) != 0); host_we = $urandom_range(0, 1) == 1;
        host_addr = AW'($urandom_range(0, 127)); host_wdata = rnd256();
      end
      cap_wren = ($urandom_range(0, 9) < 3);
      cap_addr = AW'($urandom_range(0, IMG - 1)); cap_data = rnd256();
      cap_done = ($urandom_range(0, 15) == 0);
      nn_img_release = ($urandom_range(0, 15) == 0);
      if (n == 300) do_reset();
      cycle();
    end
    clr_inputs();
    repeat (5) cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
